// File: rtl/reg_bank_arb_pkg.sv
// Shared types and helpers for the register-bank arbiter slice: FSM encoding,
// id-width rule and packed-slice offset arithmetic.
package reg_bank_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of element idx inside a packed vector of width-bit elements.
    function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/dffer.sv
// Async-reset, enable-loaded register primitive used for bank storage.
module dffer #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter: first valid request at or after the pointer wins; the
// pointer moves past the winner whenever update_i accepts the grant.
module rr_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter  int unsigned REQ_NUM = 4,
    localparam int unsigned ID_W    = id_width(REQ_NUM)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [REQ_NUM-1:0] req_i,
    input  logic               update_i,
    output logic [REQ_NUM-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               any_valid_o
);

    logic [ID_W-1:0] ptr;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        any_valid_o = 1'b0;
        grant_idx_o = '0;
        grant_o     = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            idx = (32'(ptr) + k) % REQ_NUM;
            if (!any_valid_o && req_i[idx]) begin
                any_valid_o = 1'b1;
                grant_idx_o = ID_W'(idx);
            end
        end
        if (any_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    // Pointer advances when the winner is captured; it is not consulted again
    // until the write completes, so this matches moving it in the write cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr <= '0;
        end else if (update_i) begin
            ptr <= (grant_idx_o == ID_W'(REQ_NUM - 1)) ? '0 : grant_idx_o + ID_W'(1);
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin shared configuration register bank with valid/ready write ports.
// Define REG_BANK_ARB_WSTRB_EN to add per-byte write strobes (req_wstrb_i).
module reg_bank_arbiter
    import reg_bank_arb_pkg::*;
#(
    parameter  int unsigned REQ_NUM    = 4,
    parameter  int unsigned REG_NUM    = 8,
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned ADDR_WIDTH = $clog2(REG_NUM),
    localparam int unsigned ID_W       = id_width(REQ_NUM)
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [REQ_NUM-1:0]               req_valid_i,
    output logic [REQ_NUM-1:0]               req_ready_o,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_wdata_i,
`ifdef REG_BANK_ARB_WSTRB_EN
    input  logic [REQ_NUM*DATA_WIDTH/8-1:0]  req_wstrb_i,
`endif
    input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             grant_vld_o,
    output logic [ID_W-1:0]                  grant_id_o,
    output logic                             wr_evt_o,
    output logic [ADDR_WIDTH-1:0]            wr_evt_addr_o
);

`ifdef REG_BANK_ARB_WSTRB_EN
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
`endif
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_NUM);

    state_e                 state, state_nxt;
    logic                   capture;
    logic [REQ_NUM-1:0]     grant;
    logic [ID_W-1:0]        grant_idx;
    logic                   any_valid;

    logic [ID_W-1:0]        cap_id;
    logic [ADDR_WIDTH-1:0]  cap_addr,  sel_addr;
    logic [DATA_WIDTH-1:0]  cap_data,  sel_data;
`ifdef REG_BANK_ARB_WSTRB_EN
    logic [STRB_W-1:0]      cap_strb,  sel_strb;
    logic [DATA_WIDTH-1:0]  cur_word;
`endif

    logic                   bank_wr;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic [DATA_WIDTH-1:0]  bank [REG_NUM];

    rr_arbiter #(.REQ_NUM(REQ_NUM)) u_arb (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (req_valid_i),
        .update_i    (capture),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        grant_vld_o = 1'b0;
        req_ready_o = '0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    capture   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                grant_vld_o         = 1'b1;
                req_ready_o[cap_id] = 1'b1;
                state_nxt           = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One-hot AND-OR select of the winning requester's payload.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
`ifdef REG_BANK_ARB_WSTRB_EN
        sel_strb = '0;
`endif
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            if (grant[i]) begin
                sel_addr |= req_addr_i[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                sel_data |= req_wdata_i[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
`ifdef REG_BANK_ARB_WSTRB_EN
                sel_strb |= req_wstrb_i[slice_lsb(i, STRB_W) +: STRB_W];
`endif
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            cap_id        <= '0;
            cap_addr      <= '0;
            cap_data      <= '0;
`ifdef REG_BANK_ARB_WSTRB_EN
            cap_strb      <= '0;
`endif
            wr_evt_o      <= 1'b0;
            wr_evt_addr_o <= '0;
        end else begin
            state    <= state_nxt;
            wr_evt_o <= bank_wr;
            if (capture) begin
                cap_id   <= grant_idx;
                cap_addr <= sel_addr;
                cap_data <= sel_data;
`ifdef REG_BANK_ARB_WSTRB_EN
                cap_strb <= sel_strb;
`endif
            end
            if (bank_wr) begin
                wr_evt_addr_o <= cap_addr;
            end
        end
    end

    // Out-of-range indices still handshake but never touch the bank.
    assign bank_wr    = (state == WRITE) && ({1'b0, cap_addr} < REG_LIMIT);
    assign grant_id_o = cap_id;

`ifdef REG_BANK_ARB_WSTRB_EN
    assign cur_word = bank_wr ? bank[cap_addr] : '0;
`endif

    always_comb begin
        wr_word = cap_data;
`ifdef REG_BANK_ARB_WSTRB_EN
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (!cap_strb[b]) begin
                wr_word[b*8 +: 8] = cur_word[b*8 +: 8];
            end
        end
`endif
    end

    // NOTE: the bank is reset (not left as uninitialised memory) so reads after reset return 0.
    for (genvar i = 0; i < REG_NUM; i++) begin : g_bank
        logic en;
        assign en = bank_wr && (cap_addr == ADDR_WIDTH'(i));
        dffer #(.WIDTH(DATA_WIDTH)) u_reg (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (en),
            .d_i     (wr_word),
            .q_o     (bank[i])
        );
    end

    assign rd_data_o = ({1'b0, rd_addr_i} < REG_LIMIT) ? bank[rd_addr_i] : '0;

`ifndef SV_ASSRT_DISABLE
    // A requester must keep valid asserted until its ready pulse.
    for (genvar r = 0; r < REQ_NUM; r++) begin : g_hold_chk
        a_valid_hold : assert property (@(posedge clk_i) disable iff (!rst_n_i)
            (req_valid_i[r] && !req_ready_o[r]) |=> req_valid_i[r]);
    end
`endif

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of enable-loaded configuration registers between REQ_NUM write requesters using round-robin arbitration and a valid/ready handshake.
- Provides one combinational read port and a one-cycle write-event strobe for downstream shadow logic.
- Sits between bus-side masters (debug, CPU CSR bridge, DMA descriptor loader) and the peripheral configuration registers.
- Bank storage uses the team's async-reset enable register primitive, dffer.

Parameters:
- REQ_NUM, 4, number of write requesters (2..8).
- REG_NUM, 8, number of registers in the bank.
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, $clog2(REG_NUM), register index width.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- req_valid_i  input  REQ_NUM  per-requester write request.
- req_ready_o  output  REQ_NUM  one-hot, one-cycle accept pulse.
- req_addr_i  input  REQ_NUM*ADDR_WIDTH  packed register index per requester.
- req_wdata_i  input  REQ_NUM*DATA_WIDTH  packed write data per requester.
- rd_addr_i  input  ADDR_WIDTH  read index.
- rd_data_o  output  DATA_WIDTH  combinational read of bank[rd_addr_i].
- grant_vld_o  output  1  high while in state WRITE.
- grant_id_o  output  $clog2(REQ_NUM)  index of the current or last winner.
- wr_evt_o  output  1  one-cycle pulse in the cycle after a bank write.
- wr_evt_addr_o  output  ADDR_WIDTH  index written; valid with wr_evt_o.

Behaviour:
- Reset:
  - FSM goes to IDLE and the RR pointer to 0.
  - All bank registers clear to 0, so rd_data_o reads 0.
  - req_ready_o, grant_vld_o, wr_evt_o and grant_id_o are 0.
  - Reset is asynchronous and takes effect mid-transaction: an in-flight write is dropped and ready never pulses.
- FSM state IDLE:
  - If any req_valid_i is set, the arbiter picks the first valid index at or after the pointer, wrapping modulo REQ_NUM.
  - It latches winner id, addr and data into capture registers, then goes to WRITE.
- FSM state WRITE:
  - grant_vld_o=1 and req_ready_o[id]=1 for exactly this cycle.
  - The bank enable for the captured addr is asserted, and the register updates at the end of this cycle.
  - The pointer becomes (id+1) mod REQ_NUM.
  - Next state is always IDLE.
- Timing:
  - Latency is 2 cycles from valid sampled in IDLE to the ready pulse edge.
  - rd_data_o reflects the new value the cycle after WRITE, which is the same cycle wr_evt_o=1.
  - Maximum throughput is one write per 2 cycles; back-to-back requests alternate IDLE/WRITE.
- Handshake:
  - A requester holds valid, addr and data stable until ready.
  - Deasserting valid before ready is a protocol violation, flagged by an assertion unless SV_ASSRT_DISABLE is defined.
  - The bank uses the captured copy, so payload changes after capture have no effect.
- Simultaneous events:
  - Multiple valids are resolved by the RR pointer only.
  - A requester that re-requests immediately after its grant gets lowest priority.
- Out-of-range address (addr >= REG_NUM when REG_NUM is not a power of 2):
  - The write is dropped, but ready is still pulsed.
  - wr_evt_o is not asserted.
  - A read of an out-of-range index returns 0.
- Read/write collision: reading the address being written in WRITE returns the old value.

Optional Feature:
- Macro: REG_BANK_ARB_WSTRB_EN.
- When defined:
  - Adds input req_wstrb_i [REQ_NUM*DATA_WIDTH/8], captured with the data.
  - Only bytes with strobe=1 are written; the other bytes hold their value.
  - An all-zero strobe still handshakes and pulses wr_evt_o.
- When undefined: the port is absent and full-word writes are used.

Decomposition:
- Package reg_bank_arb_pkg:
  - state_e enum {IDLE, WRITE}.
  - Function for packed-slice extraction.
  - Localparam helper for the id width ($clog2 with a minimum of 1).
- Sub-module rr_arbiter:
  - Parameter REQ_NUM.
  - Inputs: req vector and an update strobe.
  - Outputs: one-hot grant, grant index and any-valid.
  - Contains the pointer register, reset to 0.
- Bank storage: a generate loop of dffer instances, one per register, with enable = (state==WRITE) && (addr==i).

Test Plan:
- Single write: after reset, valid[2]=1, addr=3, data=0xDEADBEEF → ready[2] pulses in cycle 1, rd_data(3)=0xDEADBEEF in cycle 2, wr_evt_o=1 with addr 3 in cycle 2.
- Fairness: all 4 valids held high for 16 cycles, each to a distinct addr → grant order 0,1,2,3,0,1,2,3 with one ready every 2 cycles.
- Wrap-around: pointer=3, valid on 0 and 1 → grant 0, then 1.
- Out-of-range: REG_NUM=6, write addr=7 → ready pulses, no wr_evt_o, all registers unchanged.
- Reset mid-op: assert rst_n_i=0 in the WRITE cycle → ready drops immediately, target register reads 0, FSM is in IDLE after release.
- Strobe (REG_BANK_ARB_WSTRB_EN): reg 0 = 0x11223344, write 0xAABBCCDD with strobe 4'b0101 → reg 0 reads 0x11BB33DD.
